// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet sender slice:
//   - bank_state_t : state of one ping-pong frame bank
//   - rd_state_t   : frame read-out sequencer states
//   - ARP_REQ / ARP_RESP / UDP : packet type codes used by eth_top / eth_send
//   - HDR_* constants and make_hdr() : layout of the optional frame header word
//     {sequence[31:16], length[15:0]}
// ----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2,
        R_HOLD  = 2'd3
    } rd_state_t;

    localparam logic [1:0] ARP_REQ  = 2'd0;
    localparam logic [1:0] ARP_RESP = 2'd1;
    localparam logic [1:0] UDP      = 2'd2;

    localparam int HDR_FIELD_W = 16;
    localparam int HDR_SEQ_LSB = 16;
    localparam int HDR_LEN_LSB = 0;

    function automatic logic [31:0] make_hdr(input logic [15:0] seq,
                                             input logic [15:0] len);
        logic [31:0] w;
        w = '0;
        w[HDR_SEQ_LSB +: HDR_FIELD_W] = seq;
        w[HDR_LEN_LSB +: HDR_FIELD_W] = len;
        return w;
    endfunction

endpackage

// File: rtl/ch_frame_ram.sv
// ----------------------------------------------------------------------------
// ch_frame_ram
// Simple dual-port RAM holding both frame banks: 2^(ADDR_W+1) x 32 bits.
// The address MSB selects the bank. Registered read, one cycle latency.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : {bank, word index} write address
//   wr_data  : write word
//   rd_addr  : {bank, word index} read address, sampled every cycle
//   rd_data  : word at rd_addr from the previous cycle
// ----------------------------------------------------------------------------
module ch_frame_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [0:(2**(ADDR_W+1))-1];

    // The writer and reader always address different banks, so read-during-
    // write ordering on the same address never matters.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ch_frame_buf.sv
// ----------------------------------------------------------------------------
// ch_frame_buf
// Ping-pong frame buffer between the acquisition channel stream and the UDP
// payload path of eth_send. One bank collects the current channel frame while
// the other holds a finished frame for the sender. Frames completing while
// the other bank is still occupied are dropped and counted.
//
// Optional feature (macro CH_FRAME_HDR_EN): each frame read-out is preceded
// by a header word {seq[15:0], len[15:0]} and o_frm_len includes that word.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_ch_data/i_ch_vld: channel word and write strobe
//   i_ch_cntr         : word index within the frame
//   i_ch_complete     : frame finished pulse
//   o_frm_rdy         : a full frame is waiting to be read
//   o_frm_len/o_frm_seq : length / sequence of the ready or reading frame
//   i_rd_start        : sender claims the ready frame
//   o_rd_data/o_rd_vld/o_rd_last : read word stream
//   i_rd_next         : consume current word
//   i_rd_done         : release the frame bank (also aborts a read)
//   o_drop_cnt        : saturating count of dropped frames
// ----------------------------------------------------------------------------
module ch_frame_buf
    import eth_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEQ_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         i_ch_data,
    input  logic                i_ch_vld,
    input  logic [ADDR_W-1:0]   i_ch_cntr,
    input  logic                i_ch_complete,
    output logic                o_frm_rdy,
    output logic [ADDR_W:0]     o_frm_len,
    output logic [SEQ_W-1:0]    o_frm_seq,
    input  logic                i_rd_start,
    output logic [31:0]         o_rd_data,
    output logic                o_rd_vld,
    output logic                o_rd_last,
    input  logic                i_rd_next,
    input  logic                i_rd_done,
    output logic [15:0]         o_drop_cnt
);

`ifdef CH_FRAME_HDR_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    bank_state_t         bank_st  [0:1];
    logic [ADDR_W:0]     bank_len [0:1];
    logic [SEQ_W-1:0]    bank_seq [0:1];

    logic                wr_bank;
    logic                out_bank;
    logic [ADDR_W:0]     wr_len;
    logic [ADDR_W:0]     cntr_len;
    logic [ADDR_W:0]     eff_len;
    logic [SEQ_W-1:0]    seq;
    logic [15:0]         drop_cnt;
    logic                other_free;
    logic                frm_rdy;
    logic                frm_active;
    logic [ADDR_W:0]     frm_len;

    rd_state_t           rd_state;
    rd_state_t           rd_state_nxt;
    logic [ADDR_W:0]     rd_idx;
    logic [ADDR_W:0]     rd_idx_nxt;
    logic                rd_last;
    logic                claim;
    logic                rel_bank;

    logic [ADDR_W:0]     ram_wr_addr;
    logic [ADDR_W:0]     ram_rd_addr;
    logic [ADDR_W-1:0]   ram_rd_idx;
    logic [31:0]         ram_q;

    // The writing bank is always WRITING, so the only bank that can be FULL
    // or READING is the other one.
    assign out_bank   = ~wr_bank;
    assign other_free = (bank_st[out_bank] == BANK_FREE);

    // A word written in the same cycle as the complete pulse still counts
    // towards the frame length used by the complete decision.
    assign cntr_len = (ADDR_W+1)'(i_ch_cntr) + (ADDR_W+1)'(1);
    assign eff_len  = (i_ch_vld && (cntr_len > wr_len)) ? cntr_len : wr_len;

    assign frm_rdy    = (bank_st[out_bank] == BANK_FULL) &&
                        (bank_st[0] != BANK_READING) &&
                        (bank_st[1] != BANK_READING);
    assign frm_active = (bank_st[out_bank] == BANK_FULL) ||
                        (bank_st[out_bank] == BANK_READING);
    assign frm_len    = bank_len[out_bank] + (ADDR_W+1)'(HDR_WORDS);

    assign o_frm_rdy  = frm_rdy;
    assign o_frm_len  = frm_active ? frm_len : '0;
    assign o_frm_seq  = frm_active ? bank_seq[out_bank] : '0;
    assign o_drop_cnt = drop_cnt;

    // Bank bookkeeping: write length tracking, frame hand-over, drop count
    // and the read-side claim/release of the output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]  <= BANK_WRITING;
            bank_st[1]  <= BANK_FREE;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            bank_seq[0] <= '0;
            bank_seq[1] <= '0;
            wr_bank     <= 1'b0;
            wr_len      <= '0;
            seq         <= '0;
            drop_cnt    <= '0;
        end else begin
            if (claim) begin
                bank_st[out_bank] <= BANK_READING;
            end
            if (rel_bank) begin
                bank_st[out_bank] <= BANK_FREE;
            end
            if (i_ch_complete && (eff_len != '0)) begin
                wr_len <= '0;
                if (other_free) begin
                    bank_st[wr_bank]  <= BANK_FULL;
                    bank_st[out_bank] <= BANK_WRITING;
                    bank_len[wr_bank] <= eff_len;
                    bank_seq[wr_bank] <= seq;
                    seq               <= seq + SEQ_W'(1);
                    wr_bank           <= out_bank;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (i_ch_vld) begin
                wr_len <= eff_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_idx   <= rd_idx_nxt;
        end
    end

    assign rd_last = (rd_idx == (frm_len - (ADDR_W+1)'(1)));

    // Read sequencer: each word costs one RAM fetch cycle followed by a data
    // cycle; i_rd_done releases the bank from any non-idle state.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_idx_nxt   = rd_idx;
        claim        = 1'b0;
        rel_bank     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (i_rd_start && frm_rdy) begin
                    claim        = 1'b1;
                    rd_idx_nxt   = '0;
                    rd_state_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                if (i_rd_done) begin
                    rel_bank     = 1'b1;
                    rd_state_nxt = R_IDLE;
                end else begin
                    rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (i_rd_done) begin
                    rel_bank     = 1'b1;
                    rd_state_nxt = R_IDLE;
                end else if (i_rd_next) begin
                    if (rd_last) begin
                        rd_state_nxt = R_HOLD;
                    end else begin
                        rd_idx_nxt   = rd_idx + (ADDR_W+1)'(1);
                        rd_state_nxt = R_FETCH;
                    end
                end
            end
            R_HOLD: begin
                if (i_rd_done) begin
                    rel_bank     = 1'b1;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // With a header the stream index is one ahead of the RAM word index;
    // index 0 then maps to a don't-care RAM word that the mux below replaces.
    assign ram_rd_idx  = rd_idx[ADDR_W-1:0] - ADDR_W'(HDR_WORDS);
    assign ram_rd_addr = {out_bank, ram_rd_idx};
    assign ram_wr_addr = {wr_bank, i_ch_cntr};

    ch_frame_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (i_ch_vld),
        .wr_addr (ram_wr_addr),
        .wr_data (i_ch_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    // Output word stream; data is forced to zero whenever it is not valid so
    // that uninitialised RAM contents never reach the sender.
    always_comb begin
        o_rd_vld  = (rd_state == R_DATA);
        o_rd_last = o_rd_vld && rd_last;
        o_rd_data = '0;
        if (o_rd_vld) begin
`ifdef CH_FRAME_HDR_EN
            if (rd_idx == '0) begin
                o_rd_data = make_hdr(16'(bank_seq[out_bank]),
                                     16'(bank_len[out_bank]));
            end else begin
                o_rd_data = ram_q;
            end
`else
            o_rd_data = ram_q;
`endif
        end
    end

endmodule
